// File: rtl/rv_pkg.sv
// Shared RV32I pipeline types and constants used by the fetch and decode stages.
package rv_pkg;

  localparam int unsigned D_WIDTH = 32;

  localparam logic [D_WIDTH-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [D_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IF/ID pipeline register payload.
  typedef struct packed {
    logic [D_WIDTH-1:0] instr;
    logic [D_WIDTH-1:0] pc;
    logic [D_WIDTH-1:0] pcplus4;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Control inputs from hazard/execute and IF/ID outputs of the fetch stage.
interface fetch_stage_if;
  import rv_pkg::*;

  logic               stall;
  logic               flush;
  logic               PCSrc;
  logic [D_WIDTH-1:0] PCTarget;
  logic [D_WIDTH-1:0] PC_F;
  logic [D_WIDTH-1:0] Instr_D;
  logic [D_WIDTH-1:0] PC_D;
  logic [D_WIDTH-1:0] PCPlus4_D;
  logic               valid_D;
  logic [D_WIDTH-1:0] fetch_cnt;

  modport master (
    output stall, flush, PCSrc, PCTarget,
    input  PC_F, Instr_D, PC_D, PCPlus4_D, valid_D, fetch_cnt
  );

  modport slave (
    input  stall, flush, PCSrc, PCTarget,
    output PC_F, Instr_D, PC_D, PCPlus4_D, valid_D, fetch_cnt
  );

endinterface

// File: rtl/fetch_stage_instr_mem.sv
// Byte-organised instruction ROM with a combinational little-endian word read.
module instr_mem
  import rv_pkg::*;
#(
  parameter int unsigned A_WIDTH  = 12,
  parameter string       ROM_FILE = "program.hex"
) (
  input  logic [A_WIDTH-3:0]  addr,
  output logic [D_WIDTH-1:0]  rdata_c
);

  localparam int unsigned DEPTH = 2 ** A_WIDTH;

  // Byte array; contents are preloaded externally.
  logic [7:0] mem [0:DEPTH-1];

  assign rdata_c = {mem[{addr, 2'b11}], mem[{addr, 2'b10}],
                    mem[{addr, 2'b01}], mem[{addr, 2'b00}]};

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC select, ROM read and IF/ID register.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned        A_WIDTH  = 12,
  parameter logic [D_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter string              ROM_FILE = "program.hex"
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);

  logic [D_WIDTH-1:0] pc_q;
  logic [D_WIDTH-1:0] pc_next;
  logic [D_WIDTH-1:0] pc_plus4;
  logic [D_WIDTH-1:0] instr_f;
  logic [D_WIDTH-1:0] cnt_q;
  logic [D_WIDTH-1:0] cnt_next;
  if_id_t             if_id_q;
  if_id_t             if_id_next;

  instr_mem #(
    .A_WIDTH  (A_WIDTH),
    .ROM_FILE (ROM_FILE)
  ) u_mem (
    .addr    (pc_q[A_WIDTH-1:2]),
    .rdata_c (instr_f)
  );

  assign pc_plus4 = pc_q + D_WIDTH'(4);

  // Redirect beats stall so a taken branch is never lost behind a load-use hold.
  always_comb begin
    pc_next = pc_plus4;
    if (bus.PCSrc) begin
      pc_next = bus.PCTarget & ~D_WIDTH'(3);
    end else if (bus.stall) begin
      pc_next = pc_q;
    end
  end

  // Flush beats stall; the bubble still records the F-stage PC for debug.
  always_comb begin
    if_id_next = if_id_q;
    cnt_next   = cnt_q;
    if (bus.flush) begin
      if_id_next = '{instr: NOP_INSTR, pc: pc_q, pcplus4: pc_plus4, valid: 1'b0};
    end else if (!bus.stall) begin
      if_id_next = '{instr: instr_f, pc: pc_q, pcplus4: pc_plus4, valid: 1'b1};
      cnt_next   = cnt_q + D_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      if_id_q <= '{instr: NOP_INSTR, pc: '0, pcplus4: '0, valid: 1'b0};
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_next;
      if_id_q <= if_id_next;
      cnt_q   <= cnt_next;
    end
  end

  assign bus.PC_F      = pc_q;
  assign bus.Instr_D   = if_id_q.instr;
  assign bus.PC_D      = if_id_q.pc;
  assign bus.PCPlus4_D = if_id_q.pcplus4;
  assign bus.valid_D   = if_id_q.valid;
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: per-edge expectations queued with stimulus, checked after the edge.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc_f;
    logic [31:0] instr;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic        valid;
    logic [31:0] cnt;
  } obs_t;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        pcsrc;
    logic [31:0] target;
    obs_t        want;
  } step_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h00A0_0113;
  localparam logic [31:0] I2  = 32'h0020_81B3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  obs_t exp_q [$];

  fetch_stage_if bus ();

  fetch_stage #(
    .A_WIDTH  (12),
    .RESET_PC (32'h0000_0000),
    .ROM_FILE ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: three real instructions, address-tagged filler elsewhere.
  function automatic logic [31:0] rom_word(input int unsigned a);
    if (a == 0) return I0;
    if (a == 4) return I1;
    if (a == 8) return I2;
    return 32'h1000_0000 | 32'(a);
  endfunction

  function automatic step_t st(input logic r, input logic s, input logic f, input logic p,
                               input logic [31:0] tgt, input logic [31:0] pc_f,
                               input logic [31:0] instr, input logic [31:0] pc_d,
                               input logic [31:0] pc4_d, input logic v, input logic [31:0] cnt);
    step_t x;
    x.rst = r; x.stall = s; x.flush = f; x.pcsrc = p; x.target = tgt;
    x.want.pc_f = pc_f; x.want.instr = instr; x.want.pc_d = pc_d;
    x.want.pc4_d = pc4_d; x.want.valid = v; x.want.cnt = cnt;
    return x;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc_f = bus.PC_F; o.instr = bus.Instr_D; o.pc_d = bus.PC_D;
    o.pc4_d = bus.PCPlus4_D; o.valid = bus.valid_D; o.cnt = bus.fetch_cnt;
    return o;
  endfunction

  task automatic drive(input step_t s);
    rst          = s.rst;
    bus.stall    = s.stall;
    bus.flush    = s.flush;
    bus.PCSrc    = s.pcsrc;
    bus.PCTarget = s.target;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s [$];
    obs_t  got, want;
    s.push_back(st(1, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 32'h0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 32'h0, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(s[i].want);
      drive(s[i]);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset[%0d] got=%p want=%p", i, got, want);
      end
    end
  endtask

  task automatic test_sequential();
    step_t s [$];
    obs_t  got, want;
    s.push_back(st(0, 0, 0, 0, 0, 32'h4, I0, 32'h0, 32'h4, 1, 1));
    s.push_back(st(0, 0, 0, 0, 0, 32'h8, I1, 32'h4, 32'h8, 1, 2));
    foreach (s[i]) begin
      exp_q.push_back(s[i].want);
      drive(s[i]);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL sequential[%0d] got=%p want=%p", i, got, want);
      end
    end
  endtask

  task automatic test_stall();
    step_t s [$];
    obs_t  got, want;
    s.push_back(st(0, 1, 0, 0, 0, 32'h8, I1, 32'h4, 32'h8, 1, 2));
    s.push_back(st(0, 1, 0, 0, 0, 32'h8, I1, 32'h4, 32'h8, 1, 2));
    s.push_back(st(0, 0, 0, 0, 0, 32'hC, I2, 32'h8, 32'hC, 1, 3));
    foreach (s[i]) begin
      exp_q.push_back(s[i].want);
      drive(s[i]);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL stall[%0d] got=%p want=%p", i, got, want);
      end
    end
  endtask

  task automatic test_redirect();
    step_t s [$];
    obs_t  got, want;
    s.push_back(st(0, 0, 1, 1, 32'h40, 32'h40, NOP, 32'hC, 32'h10, 0, 3));
    s.push_back(st(0, 0, 0, 0, 32'h0, 32'h44, rom_word(32'h40), 32'h40, 32'h44, 1, 4));
    foreach (s[i]) begin
      exp_q.push_back(s[i].want);
      drive(s[i]);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL redirect[%0d] got=%p want=%p", i, got, want);
      end
    end
  endtask

  task automatic test_stall_redirect();
    step_t s [$];
    obs_t  got, want;
    // stall+PCSrc+flush: PC redirects with low bits cleared, IF/ID bubbles.
    s.push_back(st(0, 1, 1, 1, 32'h83, 32'h80, NOP, 32'h44, 32'h48, 0, 4));
    s.push_back(st(0, 0, 0, 0, 32'h0, 32'h84, rom_word(32'h80), 32'h80, 32'h84, 1, 5));
    // stall+flush without PCSrc: PC holds, IF/ID bubbles.
    s.push_back(st(0, 1, 1, 0, 32'h0, 32'h84, NOP, 32'h84, 32'h88, 0, 5));
    s.push_back(st(0, 0, 0, 0, 32'h0, 32'h88, rom_word(32'h84), 32'h84, 32'h88, 1, 6));
    foreach (s[i]) begin
      exp_q.push_back(s[i].want);
      drive(s[i]);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL stall_redirect[%0d] got=%p want=%p", i, got, want);
      end
    end
  endtask

  task automatic test_wrap_alias();
    step_t s [$];
    obs_t  got, want;
    s.push_back(st(0, 0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 32'h88, 32'h8C, 0, 6));
    s.push_back(st(0, 0, 0, 0, 32'h0, 32'h0, rom_word(32'hFFC), 32'hFFFF_FFFC, 32'h0, 1, 7));
    s.push_back(st(0, 0, 0, 0, 32'h0, 32'h4, I0, 32'h0, 32'h4, 1, 8));
    foreach (s[i]) begin
      exp_q.push_back(s[i].want);
      drive(s[i]);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL wrap_alias[%0d] got=%p want=%p", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s [$];
    obs_t  got, want;
    // Redirect without flush still delivers the sequential instruction.
    s.push_back(st(0, 0, 0, 1, 32'h24, 32'h24, I1, 32'h4, 32'h8, 1, 9));
    s.push_back(st(1, 0, 0, 0, 32'h0, 32'h0, NOP, 32'h0, 32'h0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 32'h0, 32'h4, I0, 32'h0, 32'h4, 1, 1));
    foreach (s[i]) begin
      exp_q.push_back(s[i].want);
      drive(s[i]);
      got  = sample();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset_mid[%0d] got=%p want=%p", i, got, want);
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.PCSrc    = 1'b0;
    bus.PCTarget = 32'h0;
    for (int a = 0; a < 4096; a += 4) begin
      w = rom_word(a);
      dut.u_mem.mem[a]     = w[7:0];
      dut.u_mem.mem[a + 1] = w[15:8];
      dut.u_mem.mem[a + 2] = w[23:16];
      dut.u_mem.mem[a + 3] = w[31:24];
    end
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_wrap_alias();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
